// File: rtl/parity_accum.sv
// Packet parity accumulator: XOR-reduces multi-lane beats across a packet and
// holds one result in an output register with ready/valid handshake and a saturating error counter.
//
// state | meaning
// IDLE  | no beats of the current packet accumulated yet
// ACCUM | mid-packet, acc_q holds the running parity of accepted beats
module parity_accum #(
    parameter int WIDTH = 8,
    parameter int LANES = 3,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic                     in_last,
    input  logic                     in_par,
    input  logic                     odd_mode,
    input  logic                     check_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_par,
    output logic                     out_err,
    output logic [CNT_W-1:0]         err_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic             out_par_q, out_par_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic beat_par;
    logic accept;
    logic deliver;
    logic result;

    // A held result that is being taken this cycle frees the slot immediately.
    assign in_ready = !out_valid_q || out_ready;
    assign beat_par = ^in_data;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;
    assign result   = ((state_q == ACCUM) ? acc_q : 1'b0) ^ beat_par ^ odd_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
                acc_d   = 1'b0;
            end else begin
                state_d = ACCUM;
                acc_d   = (state_q == ACCUM) ? (acc_q ^ beat_par) : beat_par;
            end
        end

        // The outgoing result is counted before a same-cycle new result overwrites it.
        if (deliver) begin
            out_valid_d = 1'b0;
            if (out_err_q && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_par_d   = result;
            out_err_d   = check_en && (result != in_par);
        end
    end

    assign out_valid = out_valid_q;
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_accum.sv
// Self-checking bench for parity_accum: directed scenarios plus random traffic
// compared against a packet-level parity model with a result queue.
module tb_parity_accum;

    localparam int WIDTH = 8;
    localparam int LANES = 3;
    localparam int CNT_W = 2;
    localparam int DW    = WIDTH * LANES;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             in_last = 1'b0;
    logic             in_par = 1'b0;
    logic             odd_mode = 1'b0;
    logic             check_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_par;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    // Second instance with 1-bit lanes.
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [2:0] b_data = '0;
    logic       b_last = 1'b0;
    logic       b_ovalid;
    logic       b_par;
    logic       b_err;
    logic [7:0] b_cnt;

    parity_accum #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode), .check_en(check_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_par(out_par), .out_err(out_err), .err_cnt(err_cnt)
    );

    parity_accum #(.WIDTH(1), .LANES(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_last(b_last), .in_par(1'b0), .odd_mode(1'b0), .check_en(1'b0),
        .out_valid(b_ovalid), .out_ready(1'b1),
        .out_par(b_par), .out_err(b_err), .err_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic par;
        logic err;
    } res_t;

    res_t m_q[$];
    logic m_acc;
    int   m_cnt;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        b_valid   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_par", out_par, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        m_q.delete();
        m_acc = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);
    endtask

    // One clock: drive, check handshake against the model, advance the model, check outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic p, input logic om, input logic ce, input logic ordy);
        logic exp_rdy;
        logic res;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l;
        in_par = p; odd_mode = om; check_en = ce; out_ready = ordy;
        #1;
        exp_rdy = (m_q.size() == 0) || ordy;
        chk("in_ready", in_ready, exp_rdy);
        if (m_q.size() != 0 && ordy) begin
            chk("dlv_par", out_par, m_q[0].par);
            chk("dlv_err", out_err, m_q[0].err);
            if (m_q[0].err && m_cnt < MAXC) m_cnt++;
            void'(m_q.pop_front());
        end
        if (v && exp_rdy) begin
            m_acc = m_acc ^ (^d);
            if (l) begin
                res = m_acc ^ om;
                m_q.push_back('{par: res, err: ce && (res != p)});
                m_acc = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, (m_q.size() != 0) ? 1 : 0);
        chk("err_cnt", err_cnt, m_cnt);
        if (m_q.size() != 0) begin
            chk("held_par", out_par, m_q[0].par);
            chk("held_err", out_err, m_q[0].err);
        end
    endtask

    initial begin
        logic [2:0]    pat [4];
        logic [DW-1:0] d;
        int            exp_cnt [5];
        pat = '{3'b010, 3'b001, 3'b010, 3'b111};
        exp_cnt = '{1, 2, 3, 3, 3};

        do_reset();

        // Single-beat packets on 1-bit lanes, even parity, result one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = 1'b1; b_data = pat[i]; b_last = 1'b1;
            if (i == 0) begin
                #1 chk("b_pre_valid", b_ovalid, 0);
            end
            @(posedge clk);
            #1;
            chk("b_valid", b_ovalid, 1);
            chk("b_par", b_par, ^pat[i]);
            chk("b_par_const", b_par, 1);
            chk("b_err", b_err, 0);
            chk("b_ready", b_ready, 1);
        end
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk);
        #1 chk("b_drained", b_ovalid, 0);
        chk("b_cnt", b_cnt, 0);

        // Three beats of parity 1 each, odd mode on the last.
        do_reset();
        step(1'b1, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'h000007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'h010000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("multi_par", out_par, 0);
        step(1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("acc_cleared", out_par, 0);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: stalled last beat is taken together with the held result's delivery.
        do_reset();
        step(1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'h000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_hold_par", out_par, 0);
        step(1'b1, 24'h000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_valid_kept", out_valid, 1);
        chk("bp_new_par", out_par, 1);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Five errored packets against a 2-bit saturating counter.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            step((i < 5) ? 1'b1 : 1'b0, d, 1'b1, ~(^d), 1'b0, 1'b1, 1'b1);
            if (i < 5) chk("sat_err", out_err, 1);
            if (i > 0) chk("sat_cnt", err_cnt, exp_cnt[i-1]);
        end

        // Reset mid-packet, then a fresh single-beat packet.
        do_reset();
        step(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'h000300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 24'h100000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_par", out_par, 1);
        chk("rst_mid_err", out_err, 0);
        chk("rst_mid_cnt", err_cnt, 0);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 DW'($urandom),
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
